// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers.
//   - key_len encodings, NB / MAX_NK / MAX_NR
//   - sbox(): forward S-box lookup
//   - xtime(): multiply by x in GF(2^8)
//   - inv_mix_col(): InvMixColumns on one 32-bit column (only with AES_KEXP_EQINV_EN)
package aes_pkg;

    localparam int unsigned NB        = 4;
    localparam int unsigned MAX_NK    = 8;
    localparam int unsigned MAX_NR    = 14;
    localparam int unsigned MAX_WORDS = NB * (MAX_NR + 1);

    typedef enum logic [1:0] {
        KeyLen128  = 2'd0,
        KeyLen192  = 2'd1,
        KeyLen256  = 2'd2,
        KeyLenRsvd = 2'd3
    } key_len_e;

    // Byte 0x00 sits in the top byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_FLAT[8 * (255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KeyLen128: return 4'd4;
            KeyLen192: return 4'd6;
            default:   return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e len);
        case (len)
            KeyLen128: return 4'd10;
            KeyLen192: return 4'd12;
            default:   return 4'd14;
        endcase
    endfunction

`ifdef AES_KEXP_EQINV_EN
    // Multiply by a 4-bit constant (0x09, 0x0b, 0x0d, 0x0e are all that is needed).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction
`endif

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Request / read-port bundle for aes_key_expand_seq.
//   master: requester (drives start, key_len, key, rk_addr[, eq_inv])
//   slave : expander (drives busy, done, err, keys_valid, nr, rk_data)
// Optional macro AES_KEXP_EQINV_EN adds eq_inv.
interface aes_key_expand_seq_if;
    import aes_pkg::*;

    logic                    start;
    logic [1:0]              key_len;
    logic [32*MAX_NK-1:0]    key;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    keys_valid;
    logic [3:0]              nr;
    logic [3:0]              rk_addr;
    logic [32*NB-1:0]        rk_data;
`ifdef AES_KEXP_EQINV_EN
    logic                    eq_inv;
`endif

    modport master (
`ifdef AES_KEXP_EQINV_EN
        output eq_inv,
`endif
        output start, key_len, key, rk_addr,
        input  busy, done, err, keys_valid, nr, rk_data
    );

    modport slave (
`ifdef AES_KEXP_EQINV_EN
        input  eq_inv,
`endif
        input  start, key_len, key, rk_addr,
        output busy, done, err, keys_valid, nr, rk_data
    );

endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, purely combinational.
//   word   : 32-bit input word
//   subbed : S-box applied to each byte
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign subbed[8*g +: 8] = sbox(word[8*g +: 8]);
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aes_key_expand_seq_if.slave (request, status, round-key read port)
// Optional macro AES_KEXP_EQINV_EN: eq_inv selects the equivalent inverse schedule
// (InvMixColumns on rounds 1..nr-1) at the read port.
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expand_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

    state_e       state_q, state_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         keys_valid_q;
    logic [3:0]   nr_q;
    logic [255:0] key_q;
    key_len_e     mode_q;
    logic [5:0]   i_q;
    logic [2:0]   ph_q;      // i mod Nk
    logic [7:0]   rcon_q;
    logic [31:0]  win_q [MAX_NK];  // win_q[7] = w[i-1], win_q[8-Nk] = w[i-Nk]
    logic [31:0]  mem [MAX_WORDS];
    logic [127:0] rk_data_q;

    logic [31:0]  key_w [MAX_NK];
    logic [3:0]   nk, nr_cur;
    logic [5:0]   nw;
    logic [2:0]   far_idx;
    logic [31:0]  prev, sub_in, sub_out, temp, new_word;
    logic         accept, last;

    always_comb begin
        for (int k = 0; k < MAX_NK; k++) begin
            key_w[k] = key_q[32*(MAX_NK-1-k) +: 32];
        end
    end

    assign nk      = nk_of(mode_q);
    assign nr_cur  = nr_of(mode_q);
    assign nw      = {nr_cur + 4'd1, 2'b00};
    assign far_idx = 3'(4'd8 - nk);
    assign prev    = win_q[MAX_NK-1];
    assign last    = (i_q == nw - 6'd1);
    assign accept  = (state_q == StIdle) && bus.start && (bus.key_len != KeyLenRsvd);

    // One shared SubWord; RotWord is applied ahead of it only on i mod Nk == 0.
    assign sub_in = (ph_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .word   (sub_in),
        .subbed (sub_out)
    );

    always_comb begin
        temp = prev;
        if (ph_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (nk == 4'd8 && i_q[1:0] == 2'b00) begin
            temp = sub_out;
        end
        new_word = win_q[far_idx] ^ temp;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StLoad;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end
            end
            StLoad:   state_d = StExpand;
            StExpand: begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q        <= '0;
            mode_q       <= KeyLen128;
            i_q          <= '0;
            ph_q         <= '0;
            rcon_q       <= '0;
            keys_valid_q <= 1'b0;
            nr_q         <= '0;
            for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        key_q        <= bus.key;
                        mode_q       <= key_len_e'(bus.key_len);
                        keys_valid_q <= 1'b0;
                    end
                end
                StLoad: begin
                    i_q    <= 6'(nk);
                    ph_q   <= '0;
                    rcon_q <= 8'h01;
                    for (int j = 0; j < MAX_NK; j++) begin
                        if (j >= int'(far_idx)) win_q[j] <= key_w[3'(j - int'(far_idx))];
                    end
                end
                StExpand: begin
                    for (int j = 0; j < MAX_NK - 1; j++) win_q[j] <= win_q[j+1];
                    win_q[MAX_NK-1] <= new_word;
                    i_q  <= i_q + 6'd1;
                    ph_q <= ({1'b0, ph_q} == nk - 4'd1) ? 3'd0 : ph_q + 3'd1;
                    if (ph_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (last) begin
                        keys_valid_q <= 1'b1;
                        nr_q         <= nr_cur;
                    end
                end
                default: ;
            endcase
        end
    end

    // Schedule storage: no reset, contents are qualified by keys_valid.
    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(nk)) mem[k] <= key_w[k];
            end
        end else if (state_q == StExpand) begin
            mem[i_q] <= new_word;
        end
    end

    logic [3:0]   rd_round;
    logic [5:0]   rd_base;
    logic [127:0] rd_key, rd_val;
    logic         rd_ok;

    // Clamp so out-of-range addresses never index past the storage.
    assign rd_round = (bus.rk_addr > 4'(MAX_NR)) ? 4'd0 : bus.rk_addr;
    assign rd_base  = {rd_round, 2'b00};
    assign rd_key   = {mem[rd_base], mem[rd_base | 6'd1], mem[rd_base | 6'd2],
                       mem[rd_base | 6'd3]};
    assign rd_ok    = keys_valid_q && (bus.rk_addr <= nr_q);

`ifdef AES_KEXP_EQINV_EN
    always_comb begin
        rd_val = rd_key;
        if (bus.eq_inv && bus.rk_addr >= 4'd1 && bus.rk_addr < nr_q) begin
            for (int c = 0; c < NB; c++) begin
                rd_val[32*c +: 32] = inv_mix_col(rd_key[32*c +: 32]);
            end
        end
    end
`else
    assign rd_val = rd_key;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data_q <= '0;
        end else begin
            rk_data_q <= rd_ok ? rd_val : '0;
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.nr         = nr_q;
    assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 known answers for all three
// key lengths, done latency, err / ignored-start handshakes and mid-run reset.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_seq_if bus ();

    aes_key_expand_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [1:0]   len;
        logic [3:0]   addr;
        logic [127:0] exp;
    } rd_vec_t;

    rd_vec_t      vecs [$];
    logic [127:0] exp_q [$];
    logic [127:0] a1_rk [11];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address driven at negedge, result compared one clock edge later.
    task automatic read_rk(input logic [3:0] a, input logic inv, input logic [127:0] exp,
                           input string name);
        @(negedge clk);
        bus.rk_addr = a;
`ifdef AES_KEXP_EQINV_EN
        bus.eq_inv = inv;
`else
        if (inv) $display("note: eq_inv requested but feature not built");
`endif
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d]", name, a), bus.rk_data, exp_q.pop_front());
    endtask

    // Cycle 1 is the edge that samples start; done must be seen after edge exp_cyc.
    task automatic run_exp(input logic [1:0] len, input logic [255:0] k, input int exp_cyc,
                           input logic [3:0] exp_nr, input int inject_at, input string name);
        int cycles;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key_len = len;
        bus.key = k;
        @(posedge clk);
        cycles = 1;
        #1;
        bus.start = 1'b0;
        check({name, "_busy"}, 128'(bus.busy), 128'd1);
        check({name, "_kv_clear"}, 128'(bus.keys_valid), 128'd0);
        while (!bus.done && cycles < 200) begin
            if (cycles == inject_at) begin
                bus.start = 1'b1;
                bus.key_len = 2'd0;
                bus.key = K128;
            end
            @(posedge clk);
            cycles++;
            #1;
            bus.start = 1'b0;
        end
        check({name, "_done_cycle"}, 128'(cycles), 128'(exp_cyc));
        check({name, "_kv"}, 128'(bus.keys_valid), 128'd1);
        check({name, "_nr"}, 128'(bus.nr), 128'(exp_nr));
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 128'(bus.done), 128'd0);
        check({name, "_idle"}, 128'(bus.busy), 128'd0);
    endtask

`ifdef AES_KEXP_EQINV_EN
    function automatic logic [7:0] tb_gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] tb_inv_mix(input logic [127:0] rk);
        logic [127:0] r;
        logic [7:0] s0, s1, s2, s3;
        for (int c = 0; c < 4; c++) begin
            {s0, s1, s2, s3} = rk[32*c +: 32];
            r[32*c +: 32] = {
                tb_gm(s0, 8'h0e) ^ tb_gm(s1, 8'h0b) ^ tb_gm(s2, 8'h0d) ^ tb_gm(s3, 8'h09),
                tb_gm(s0, 8'h09) ^ tb_gm(s1, 8'h0e) ^ tb_gm(s2, 8'h0b) ^ tb_gm(s3, 8'h0d),
                tb_gm(s0, 8'h0d) ^ tb_gm(s1, 8'h09) ^ tb_gm(s2, 8'h0e) ^ tb_gm(s3, 8'h0b),
                tb_gm(s0, 8'h0b) ^ tb_gm(s1, 8'h0d) ^ tb_gm(s2, 8'h09) ^ tb_gm(s3, 8'h0e)};
        end
        return r;
    endfunction
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        a1_rk = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                  128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                  128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                  128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                  128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        for (int r = 0; r < 11; r++) vecs.push_back('{2'd0, 4'(r), a1_rk[r]});
        vecs.push_back('{2'd0, 4'd11, 128'h0});
        vecs.push_back('{2'd1, 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5});
        vecs.push_back('{2'd1, 4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5});
        vecs.push_back('{2'd1, 4'd12, 128'he98ba06f448c773c8ecc720401002202});
        vecs.push_back('{2'd1, 4'd13, 128'h0});
        vecs.push_back('{2'd2, 4'd0, 128'h603deb1015ca71be2b73aef0857d7781});
        vecs.push_back('{2'd2, 4'd1, 128'h1f352c073b6108d72d9810a30914dff4});
        vecs.push_back('{2'd2, 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde});
        vecs.push_back('{2'd2, 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a});
        vecs.push_back('{2'd2, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e});
        vecs.push_back('{2'd2, 4'd15, 128'h0});

        bus.start = 1'b0;
        bus.key_len = 2'd0;
        bus.key = '0;
        bus.rk_addr = 4'd0;
`ifdef AES_KEXP_EQINV_EN
        bus.eq_inv = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_err", 128'(bus.err), 128'd0);
        check("rst_kv", 128'(bus.keys_valid), 128'd0);
        check("rst_nr", 128'(bus.nr), 128'd0);
        check("rst_rk", bus.rk_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read before any expansion: keys_valid is low, so data must be zero.
        read_rk(4'd0, 1'b0, 128'h0, "rk_before_valid");

        // Table-driven known answers, one expansion per key length.
        for (int m = 0; m < 3; m++) begin
            case (m)
                0: run_exp(2'd0, K128, 42, 4'd10, 0, "aes128");
                1: run_exp(2'd1, K192, 48, 4'd12, 0, "aes192");
                default: run_exp(2'd2, K256, 54, 4'd14, 0, "aes256");
            endcase
            foreach (vecs[v]) begin
                if (vecs[v].len == 2'(m)) read_rk(vecs[v].addr, 1'b0, vecs[v].exp, "kat");
            end
        end

        // Reserved key_len: err pulse, nothing else moves.
        @(negedge clk);
        bus.start = 1'b1;
        bus.key_len = 2'd3;
        bus.key = K128;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("rsvd_err", 128'(bus.err), 128'd1);
        check("rsvd_busy", 128'(bus.busy), 128'd0);
        check("rsvd_kv", 128'(bus.keys_valid), 128'd1);
        @(posedge clk);
        #1;
        check("rsvd_err_pulse", 128'(bus.err), 128'd0);
        check("rsvd_busy2", 128'(bus.busy), 128'd0);
        read_rk(4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, "rsvd_keep");

        // Second start at cycle 10 is ignored: AES-256 result survives.
        run_exp(2'd2, K256, 54, 4'd14, 10, "restart");
        read_rk(4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e, "restart_rk");

        // Reset at cycle 20 of an AES-256 run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.key_len = 2'd2;
        bus.key = K256;
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("midrst_busy_pre", 128'(bus.busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(bus.busy), 128'd0);
        check("midrst_kv", 128'(bus.keys_valid), 128'd0);
        check("midrst_nr", 128'(bus.nr), 128'd0);
        check("midrst_rk", bus.rk_data, 128'd0);
        check("midrst_done", 128'(bus.done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("midrst_no_done", 128'(saw_done), 128'd0);
        run_exp(2'd0, K128, 42, 4'd10, 0, "post_rst");
        read_rk(4'd1, 1'b0, a1_rk[1], "post_rst_rk");
        read_rk(4'd10, 1'b0, a1_rk[10], "post_rst_rk");

`ifdef AES_KEXP_EQINV_EN
        read_rk(4'd0, 1'b1, a1_rk[0], "eqinv");
        read_rk(4'd10, 1'b1, a1_rk[10], "eqinv");
        for (int r = 1; r < 10; r++) read_rk(4'(r), 1'b1, tb_inv_mix(a1_rk[r]), "eqinv");
        read_rk(4'd5, 1'b0, a1_rk[5], "eqinv_off");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
